// File: rtl/adder_pipe_if.sv
// adder_pipe_if
//   Handshake and operand/result bundle for adder_pipe.
//   Optional macro: ADDER_PIPE_OVF_EN adds the signed-overflow result bit (ovf).
// Signals
//   in_valid / in_ready    input beat handshake
//   a, b [WIDTH]           operands (unsigned or two's complement)
//   cin                    carry-in, ignored for subtraction
//   sub                    0: a+b+cin, 1: a-b
//   out_valid / out_ready  result beat handshake
//   sum [WIDTH], cout      result and carry out of the MSB (sub: 1 = no borrow)
//   ovf                    signed overflow (ADDER_PIPE_OVF_EN only)
// Modports
//   master  drives operands and out_ready (producer/consumer side)
//   slave   the adder itself
interface adder_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_PIPE_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
`ifdef ADDER_PIPE_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
`ifdef ADDER_PIPE_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/adder_pipe.sv
// adder_pipe
//   Pipelined ripple-carry adder/subtractor. A WIDTH-bit operation is cut
//   into STAGES equal slices of SW = WIDTH/STAGES bits; stage k adds slice k
//   using the carry registered by stage k-1. Unconsumed operand slices ride
//   along with the beat, finished low sum slices ride along to the output,
//   so every output beat is a coherent WIDTH-bit result. Latency is STAGES
//   cycles with no stall, throughput one beat per cycle.
//   Optional macro: ADDER_PIPE_OVF_EN adds a registered signed-overflow flag.
// Parameters
//   WIDTH   operand/result width, must be a multiple of STAGES
//   STAGES  number of pipeline stages (>= 1)
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset, clears every stage
//   bus     adder_pipe_if.slave: in_valid/in_ready, a, b, cin, sub,
//           out_valid/out_ready, sum, cout (and ovf when enabled)
module adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  adder_pipe_if.slave   bus
);

  localparam int NST = (STAGES < 1) ? 1 : STAGES;
  localparam int SW  = WIDTH / NST;

  if (STAGES < 1 || (WIDTH % NST) != 0) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  logic advance;
  logic out_valid;

  // The whole pipe moves in lockstep; it only freezes when a finished
  // result is waiting for a consumer that is not ready.
  assign advance     = !out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar gi = 0; gi < NST; gi++) begin : stg
    localparam int LO = gi * SW;

    // Operand bits from this slice upwards; lower bits are already summed.
    logic [WIDTH-1:LO]    a_in;
    logic [WIDTH-1:LO]    bx_in;
    logic                 c_in;
    logic                 v_in;
    logic [SW:0]          slice;
    logic [LO+SW-1:0]     sum_next;
    logic [LO+SW-1:0]     sum_reg;
    logic                 carry_reg;
    logic                 valid_reg;

    if (gi == 0) begin : src
      // Subtraction is folded in here: invert B and force carry-in to 1.
      assign a_in     = bus.a;
      assign bx_in    = bus.sub ? ~bus.b : bus.b;
      assign c_in     = bus.sub ? 1'b1 : bus.cin;
      assign v_in     = bus.in_valid;
      assign sum_next = slice[SW-1:0];
    end else begin : src
      assign a_in     = stg[gi-1].fwd.a_reg;
      assign bx_in    = stg[gi-1].fwd.bx_reg;
      assign c_in     = stg[gi-1].carry_reg;
      assign v_in     = stg[gi-1].valid_reg;
      assign sum_next = {slice[SW-1:0], stg[gi-1].sum_reg};
    end

    assign slice = {1'b0, a_in[LO +: SW]} + {1'b0, bx_in[LO +: SW]}
                 + {{SW{1'b0}}, c_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        carry_reg <= 1'b0;
        sum_reg   <= '0;
      end else if (advance) begin
        valid_reg <= v_in;
        carry_reg <= slice[SW];
        sum_reg   <= sum_next;
      end
    end

    // Operand skew: only the slices later stages still need are carried.
    if (gi < NST - 1) begin : fwd
      logic [WIDTH-1:LO+SW] a_reg;
      logic [WIDTH-1:LO+SW] bx_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_reg  <= '0;
          bx_reg <= '0;
        end else if (advance) begin
          a_reg  <= a_in[WIDTH-1:LO+SW];
          bx_reg <= bx_in[WIDTH-1:LO+SW];
        end
      end
    end

`ifdef ADDER_PIPE_OVF_EN
    // Signed overflow: operands of equal sign producing a result of the
    // opposite sign. Only the top slice sees all three sign bits.
    if (gi == NST - 1) begin : g_ovf
      logic ovf_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_reg <= 1'b0;
        end else if (advance) begin
          ovf_reg <= (a_in[WIDTH-1] == bx_in[WIDTH-1]) &&
                     (slice[SW-1] != a_in[WIDTH-1]);
        end
      end
    end
`endif
  end

  assign out_valid     = stg[NST-1].valid_reg;
  assign bus.out_valid = out_valid;
  assign bus.sum       = stg[NST-1].sum_reg;
  assign bus.cout      = stg[NST-1].carry_reg;
`ifdef ADDER_PIPE_OVF_EN
  assign bus.ovf       = stg[NST-1].g_ovf.ovf_reg;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe
//   Drives three adder_pipe instances (8/2, 32/4, 4/1) from one directed
//   sequence, with a per-instance queue of expected results computed by
//   plain integer arithmetic. Build with ADDER_PIPE_OVF_EN to also check ovf.
module tb_adder_pipe;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0][31:0] drv_a, drv_b, mon_sum;
  logic [NDUT-1:0]       drv_cin, drv_sub, drv_iv, drv_or;
  logic [NDUT-1:0]       mon_ov, mon_ir, mon_cout, mon_ovf;

  int cfg_w [NDUT] = '{8, 32, 4};
  int cfg_s [NDUT] = '{2, 4, 1};

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int W = (gi == 0) ? 8 : (gi == 1) ? 32 : 4;
    localparam int S = (gi == 0) ? 2 : (gi == 1) ? 4 : 1;

    adder_pipe_if #(.WIDTH(W)) bus ();

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.a         = drv_a[gi][W-1:0];
    assign bus.b         = drv_b[gi][W-1:0];
    assign bus.cin       = drv_cin[gi];
    assign bus.sub       = drv_sub[gi];
    assign bus.in_valid  = drv_iv[gi];
    assign bus.out_ready = drv_or[gi];
    assign mon_sum[gi]   = 32'(bus.sum);
    assign mon_cout[gi]  = bus.cout;
    assign mon_ov[gi]    = bus.out_valid;
    assign mon_ir[gi]    = bus.in_ready;
`ifdef ADDER_PIPE_OVF_EN
    assign mon_ovf[gi]   = bus.ovf;
`else
    assign mon_ovf[gi]   = 1'b0;
`endif
  end

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
    int          stall_at;
  } beat_t;

  beat_t sb_q [NDUT][$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    stall_cnt [NDUT];
  int    acc_cnt [NDUT];
  bit    adv_prev [NDUT];
  bit    acc_last [NDUT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the arithmetic result of the operation, no slicing.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub,
                                output logic [31:0] s, output logic co, output logic ov);
    longint unsigned m, ua, ub, full;
    longint sa, sb, r, lim;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & m;
    ub = {32'd0, b} & m;
    if (sub) begin
      full = (ua - ub) & m;
      co   = (ua >= ub);
    end else begin
      full = ua + ub + {63'd0, cin};
      co   = full[w];
    end
    s   = 32'(full & m);
    lim = longint'(64'd1 << (w - 1));
    sa  = longint'(ua);
    sb  = longint'(ub);
    if (sa >= lim) sa = sa - 2 * lim;
    if (sb >= lim) sb = sb - 2 * lim;
    r  = sub ? (sa - sb) : (sa + sb + longint'({63'd0, cin}));
    ov = (r >= lim) || (r < -lim);
  endfunction

  // One clock: settle inputs, account handshakes, let the edge pass,
  // then check whatever the DUTs present.
  task automatic tick();
    beat_t bt;
    logic  adv;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      adv = !mon_ov[d] || drv_or[d];
      chk($sformatf("in_ready_rule[%0d]", d), 32'(mon_ir[d]), 32'(adv));
      if (mon_ov[d] && drv_or[d] && sb_q[d].size() > 0) void'(sb_q[d].pop_front());
      acc_last[d] = drv_iv[d] && adv;
      if (acc_last[d]) begin
        model(cfg_w[d], drv_a[d], drv_b[d], drv_cin[d], drv_sub[d], bt.sum, bt.cout, bt.ovf);
        bt.acc_cyc  = cyc;
        bt.stall_at = stall_cnt[d];
        sb_q[d].push_back(bt);
        acc_cnt[d]++;
      end
      if (!adv) stall_cnt[d]++;
      adv_prev[d] = adv;
    end
    @(negedge clk);
    cyc++;
    for (int d = 0; d < NDUT; d++) begin
      if (mon_ov[d] === 1'b1) begin
        if (sb_q[d].size() == 0) begin
          chk($sformatf("spurious_out[%0d]", d), 32'(mon_ov[d]), 32'd0);
        end else begin
          bt = sb_q[d][0];
          chk($sformatf("sum[%0d]", d), mon_sum[d], bt.sum);
          chk($sformatf("cout[%0d]", d), 32'(mon_cout[d]), 32'(bt.cout));
`ifdef ADDER_PIPE_OVF_EN
          chk($sformatf("ovf[%0d]", d), 32'(mon_ovf[d]), 32'(bt.ovf));
`endif
          if (adv_prev[d])
            chk($sformatf("latency[%0d]", d), 32'(cyc - bt.acc_cyc),
                32'(cfg_s[d] + stall_cnt[d] - bt.stall_at));
        end
      end
    end
  endtask

  task automatic set0(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    drv_a[0] = a; drv_b[0] = b; drv_cin[0] = cin; drv_sub[0] = sub; drv_iv[0] = 1'b1;
  endtask

  task automatic drain();
    drv_iv = '0;
    drv_or = '1;
    repeat (8) tick();
  endtask

  initial begin
    logic [31:0] held;
    int sent, guard;
    bit  done;

    drv_a = '0; drv_b = '0; drv_cin = '0; drv_sub = '0; drv_iv = '0; drv_or = '1;
    for (int d = 0; d < NDUT; d++) begin
      stall_cnt[d] = 0; acc_cnt[d] = 0; adv_prev[d] = 1'b1; acc_last[d] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rst_out_valid[%0d]", d), 32'(mon_ov[d]), 32'd0);
      chk($sformatf("rst_sum[%0d]", d), mon_sum[d], 32'd0);
      chk($sformatf("rst_cout[%0d]", d), 32'(mon_cout[d]), 32'd0);
      chk($sformatf("rst_ovf[%0d]", d), 32'(mon_ovf[d]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++)
      chk($sformatf("rel_in_ready[%0d]", d), 32'(mon_ir[d]), 32'd1);

    // Carry crosses the slice boundary; exact two-cycle latency
    set0(32'h0F, 32'h01, 1'b0, 1'b0);
    tick();
    drv_iv[0] = 1'b0;
    chk("t2_not_yet", 32'(mon_ov[0]), 32'd0);
    tick();
    chk("t2_valid", 32'(mon_ov[0]), 32'd1);
    chk("t2_sum", mon_sum[0], 32'h10);
    chk("t2_cout", 32'(mon_cout[0]), 32'd0);
    drain();

    // Add with carry-in wrapping, then back-to-back subtract with borrow
    set0(32'hFF, 32'h01, 1'b1, 1'b0);
    tick();
    set0(32'h05, 32'h07, 1'b1, 1'b1);
    tick();
    drv_iv[0] = 1'b0;
    chk("t3_sum_add", mon_sum[0], 32'h01);
    chk("t3_cout_add", 32'(mon_cout[0]), 32'd1);
    tick();
    chk("t3_sum_sub", mon_sum[0], 32'hFE);
    chk("t3_cout_sub", 32'(mon_cout[0]), 32'd0);
    drain();

`ifdef ADDER_PIPE_OVF_EN
    // Signed overflow cases
    set0(32'h7F, 32'h01, 1'b0, 1'b0);
    tick();
    set0(32'h80, 32'h01, 1'b0, 1'b1);
    tick();
    chk("t5_ovf_add", 32'(mon_ovf[0]), 32'd1);
    set0(32'h10, 32'h20, 1'b0, 1'b0);
    tick();
    drv_iv[0] = 1'b0;
    chk("t5_ovf_sub", 32'(mon_ovf[0]), 32'd1);
    tick();
    chk("t5_ovf_none", 32'(mon_ovf[0]), 32'd0);
    drain();
`endif

    // Eight back-to-back beats with a three-cycle output stall
    sent = 0;
    set0($urandom, $urandom, 1'($urandom), 1'($urandom));
    for (int step = 0; step < 16; step++) begin
      drv_iv[0] = (sent < 8);
      drv_or[0] = !(step >= 4 && step <= 6);
      if (!drv_or[0]) begin
        #1;
        chk("t4_stall_in_ready", 32'(mon_ir[0]), 32'd0);
        held = mon_sum[0];
      end
      tick();
      if (step >= 4 && step <= 6) chk("t4_stall_hold", mon_sum[0], held);
      if (acc_last[0]) begin
        sent++;
        drv_a[0] = $urandom; drv_b[0] = $urandom;
        drv_cin[0] = 1'($urandom); drv_sub[0] = 1'($urandom);
      end
    end
    drain();
    chk("t4_sent", 32'(sent), 32'd8);
    chk("t4_all_out", 32'(sb_q[0].size()), 32'd0);

    // Reset with two beats in flight
    set0($urandom, $urandom, 1'b0, 1'b0);
    tick();
    set0($urandom, $urandom, 1'b1, 1'b0);
    tick();
    drv_iv = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_rst_out_valid", 32'(mon_ov[0]), 32'd0);
    chk("t1_rst_sum", mon_sum[0], 32'd0);
    for (int d = 0; d < NDUT; d++) sb_q[d].delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_no_out_after_rst", 32'(mon_ov[0]), 32'd0);
    end

    // Random traffic on all three configurations
    for (int d = 0; d < NDUT; d++) acc_cnt[d] = 0;
    guard = 0;
    done  = 1'b0;
    while (!done && guard < 20000) begin
      for (int d = 0; d < NDUT; d++) begin
        drv_iv[d]  = ($urandom_range(0, 3) != 0);
        drv_or[d]  = ($urandom_range(0, 3) != 0);
        drv_a[d]   = $urandom;
        drv_b[d]   = $urandom;
        drv_cin[d] = 1'($urandom);
        drv_sub[d] = 1'($urandom);
      end
      tick();
      guard++;
      done = (acc_cnt[0] >= 1000) && (acc_cnt[1] >= 1000) && (acc_cnt[2] >= 1000);
    end
    chk("t6_budget", 32'(done), 32'd1);
    drain();
    for (int d = 0; d < NDUT; d++)
      chk($sformatf("t6_all_out[%0d]", d), 32'(sb_q[d].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
